// File: rtl/icache_refill_ctrl_if.sv
// icache_refill_ctrl_if: fetch, cache-RAM, flush and memory-bus signals of the refill controller
interface icache_refill_ctrl_if #(
    parameter int WPL = 8,
    parameter int INDEX_BITS = 7
);
    logic DStrobe, DRW, Match, Valid, Flush, MGrant, mSDR_RxD;
    logic [$clog2(WPL)-1:0] DWordSel;
    logic DReady, DDataSelect, Hit, Miss, TagWrite, ValidWrite, ValidData;
    logic [WPL-1:0] RamWrite;
    logic IndexSel, FlushDone, MStrobe, MRW, MAddrOE;
    logic [INDEX_BITS-1:0] FlushIndex;
    modport slave (
        input DStrobe, DRW, DWordSel, Match, Valid, Flush, MGrant, mSDR_RxD,
        output DReady, DDataSelect, Hit, Miss, TagWrite, ValidWrite, ValidData, RamWrite,
        output IndexSel, FlushIndex, FlushDone, MStrobe, MRW, MAddrOE
    );
    modport master (
        output DStrobe, DRW, DWordSel, Match, Valid, Flush, MGrant, mSDR_RxD,
        input DReady, DDataSelect, Hit, Miss, TagWrite, ValidWrite, ValidData, RamWrite,
        input IndexSel, FlushIndex, FlushDone, MStrobe, MRW, MAddrOE
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: I-cache lookup/refill/flush FSM with early restart and grant-loss retry
module icache_refill_ctrl #(
    parameter int WPL = 8,
    parameter int INDEX_BITS = 7,
    parameter int EARLY_RESTART = 1
) (
    input logic Clk,
    input logic Reset,
    icache_refill_ctrl_if.slave bus
);
    localparam int WB = $clog2(WPL);
    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, FILL, DONE, FLUSH} state_t;
    state_t state;
    logic [WB-1:0] count, word_sel;
    logic [INDEX_BITS-1:0] flush_index;
    logic pending, served, hit, abort, beat, last, early, sweep_end;
    // Per-cycle events derived from state and inputs; a beat only counts while the grant is held
    always_comb begin
        hit = state == LOOKUP && bus.Match && bus.Valid;
        abort = state == FILL && !bus.MGrant;
        beat = state == FILL && bus.MGrant && bus.mSDR_RxD;
        last = beat && count == WB'(WPL - 1);
        early = EARLY_RESTART != 0 && beat && !served && count == word_sel;
        sweep_end = state == FLUSH && &flush_index;
    end
    // State, beat counter, flush sweep and the pending/served bookkeeping
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            count <= '0;
            word_sel <= '0;
            flush_index <= '0;
            pending <= 1'b0;
            served <= 1'b0;
        end else begin
            pending <= sweep_end ? 1'b0 : pending | (bus.Flush && state != IDLE && state != FLUSH);
            case (state)
                IDLE: begin
                    if (bus.Flush || pending) begin
                        state <= FLUSH;
                    end else if (bus.DStrobe && bus.DRW) begin
                        state <= LOOKUP;
                        word_sel <= bus.DWordSel;
                        served <= 1'b0;
                    end
                end
                LOOKUP: state <= hit ? IDLE : MISS_REQ;
                MISS_REQ: begin
                    if (bus.MGrant) begin
                        state <= FILL;
                        count <= '0;
                    end
                end
                FILL: begin
                    if (abort) begin
                        state <= MISS_REQ;
                        count <= '0;
                    end else if (beat) begin
                        count <= count + 1'b1;
                        if (last) state <= DONE;
                    end
                    if (early) served <= 1'b1;
                end
                DONE: state <= IDLE;
                FLUSH: begin
                    flush_index <= flush_index + 1'b1;
                    if (sweep_end) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Outputs decode straight from state and inputs; IDLE drives them all low, which covers reset
    always_comb begin
        bus.Hit = hit;
        bus.DReady = hit || early || (state == DONE && !served);
        bus.DDataSelect = early;
        bus.Miss = state == MISS_REQ || state == FILL;
        bus.TagWrite = last;
        bus.ValidWrite = (state == MISS_REQ && bus.MGrant) || last || state == FLUSH;
        bus.ValidData = last;
        bus.RamWrite = beat ? WPL'(1) << count : '0;
        bus.IndexSel = state == FLUSH;
        bus.FlushIndex = flush_index;
        bus.FlushDone = sweep_end;
        bus.MStrobe = state == MISS_REQ;
        bus.MRW = state == MISS_REQ || state == FILL;
        bus.MAddrOE = state == FILL;
    end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: scoreboard bench for the I-cache refill controller
module tb_icache_refill_ctrl;
    logic Clk = 1'b0;
    logic Reset;
    int n_checks = 0;
    int n_fail = 0;
    int dr_seen = 0;
    logic [3:0] cur_idx = '0;
    logic [3:0] cur_tag = '0;
    logic valid_ram [16] = '{default: 1'b0};
    logic [3:0] tag_ram [16] = '{default: 4'h0};
    logic [8:0] dr_q [$];
    logic [7:0] rw_q [$];
    logic [7:0] vw_q [$];
    logic [8:0] dr_e;
    logic [7:0] rw_e, vw_e;
    logic [23:0] outs0, outs1;

    icache_refill_ctrl_if #(.WPL(8), .INDEX_BITS(4)) b0 ();
    icache_refill_ctrl_if #(.WPL(8), .INDEX_BITS(4)) b1 ();

    icache_refill_ctrl #(.WPL(8), .INDEX_BITS(4), .EARLY_RESTART(1)) dut0 (.Clk(Clk), .Reset(Reset), .bus(b0));
    icache_refill_ctrl #(.WPL(8), .INDEX_BITS(4), .EARLY_RESTART(0)) dut1 (.Clk(Clk), .Reset(Reset), .bus(b1));

    always #5 Clk = ~Clk;

    assign b0.Valid = valid_ram[cur_idx];
    assign b0.Match = tag_ram[cur_idx] == cur_tag;
    assign b1.DStrobe = b0.DStrobe;
    assign b1.DRW = b0.DRW;
    assign b1.DWordSel = b0.DWordSel;
    assign b1.Match = b0.Match;
    assign b1.Valid = b0.Valid;
    assign b1.Flush = b0.Flush;
    assign b1.MGrant = b0.MGrant;
    assign b1.mSDR_RxD = b0.mSDR_RxD;
    assign outs0 = {b0.DReady, b0.DDataSelect, b0.Hit, b0.Miss, b0.TagWrite, b0.ValidWrite, b0.ValidData,
                    b0.RamWrite, b0.IndexSel, b0.FlushIndex, b0.FlushDone, b0.MStrobe, b0.MRW, b0.MAddrOE};
    assign outs1 = {b1.DReady, b1.DDataSelect, b1.Hit, b1.Miss, b1.TagWrite, b1.ValidWrite, b1.ValidData,
                    b1.RamWrite, b1.IndexSel, b1.FlushIndex, b1.FlushDone, b1.MStrobe, b1.MRW, b1.MAddrOE};

    always @(posedge Clk) begin
        if (b0.ValidWrite === 1'b1) valid_ram[b0.IndexSel ? b0.FlushIndex : cur_idx] <= b0.ValidData;
        if (b0.TagWrite === 1'b1) tag_ram[cur_idx] <= cur_tag;
    end

    always @(negedge Clk) begin
        if (Reset === 1'b0) begin
            if (b0.DReady !== 1'b0) begin
                dr_seen++;
                n_checks++;
                if (dr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dready_unexpected: got dds=%b ramwrite=%h, required no pulse", b0.DDataSelect, b0.RamWrite);
                end else begin
                    dr_e = dr_q.pop_front();
                    if ({b0.DDataSelect, b0.RamWrite} !== dr_e) begin
                        n_fail++;
                        $display("FAIL dready_event: got {dds,ramwrite}=%h required %h", {b0.DDataSelect, b0.RamWrite}, dr_e);
                    end
                end
            end
            if (b0.RamWrite !== 8'h00) begin
                n_checks++;
                if (rw_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ramwrite_unexpected: got %h required 00", b0.RamWrite);
                end else begin
                    rw_e = rw_q.pop_front();
                    if (b0.RamWrite !== rw_e) begin
                        n_fail++;
                        $display("FAIL ramwrite_order: got %h required %h", b0.RamWrite, rw_e);
                    end
                end
            end
            if (b0.ValidWrite !== 1'b0) begin
                n_checks++;
                if (vw_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL validwrite_unexpected: got vd=%b isel=%b idx=%h", b0.ValidData, b0.IndexSel, b0.FlushIndex);
                end else begin
                    vw_e = vw_q.pop_front();
                    if ({b0.ValidData, b0.IndexSel, b0.TagWrite, b0.FlushDone, b0.FlushIndex} !== vw_e) begin
                        n_fail++;
                        $display("FAIL validwrite_event: got {vd,isel,tagw,fdone,fidx}=%b required %b",
                                 {b0.ValidData, b0.IndexSel, b0.TagWrite, b0.FlushDone, b0.FlushIndex}, vw_e);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] idx, input logic [3:0] tag, input int word);
        cur_idx = idx;
        cur_tag = tag;
        b0.DWordSel = 3'(word);
        b0.DStrobe = 1'b1;
        b0.DRW = 1'b1;
        cyc();
        b0.DStrobe = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        b0.DStrobe = 1'b1;
        b0.DRW = 1'b1;
        b0.DWordSel = '0;
        b0.Flush = 1'b1;
        b0.MGrant = 1'b1;
        b0.mSDR_RxD = 1'b1;
        repeat (2) @(negedge Clk);
        n_checks++;
        if (outs0 !== 24'h0 || outs1 !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%h required 000000", outs0, outs1);
        end
        b0.DStrobe = 1'b0;
        b0.Flush = 1'b0;
        b0.MGrant = 1'b0;
        b0.mSDR_RxD = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        cyc();
        @(negedge Clk);
        n_checks++;
        if (outs0 !== 24'h0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h required 000000", outs0);
        end
    endtask

    task automatic test_miss(input logic [3:0] idx, input logic [3:0] tag, input int word, input int gdelay);
        logic [7:0] oh;
        int d1;
        d1 = 0;
        oh = 8'd1 << word;
        vw_q.push_back(8'b0000_0000);
        for (int i = 0; i < 8; i++) rw_q.push_back(8'd1 << i);
        dr_q.push_back({1'b1, oh});
        vw_q.push_back(8'b1010_0000);
        issue(idx, tag, word);
        @(negedge Clk);
        n_checks++;
        if (b0.Hit !== 1'b0 || b0.DReady !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_lookup: got hit=%b dready=%b required 0 0", b0.Hit, b0.DReady);
        end
        cyc();
        for (int i = 0; i < gdelay; i++) begin
            @(negedge Clk);
            n_checks++;
            if ({b0.MStrobe, b0.MRW, b0.Miss, b0.ValidWrite} !== 4'b1110) begin
                n_fail++;
                $display("FAIL miss_req: got {mstrobe,mrw,miss,vw}=%b required 1110", {b0.MStrobe, b0.MRW, b0.Miss, b0.ValidWrite});
            end
            cyc();
        end
        b0.MGrant = 1'b1;
        cyc();
        for (int b = 0; b < 8; b++) begin
            b0.mSDR_RxD = 1'b1;
            @(negedge Clk);
            if (b1.DReady === 1'b1) d1++;
            n_checks++;
            if ({b0.MAddrOE, b0.MRW, b0.Miss, b0.MStrobe} !== 4'b1110) begin
                n_fail++;
                $display("FAIL fill_bus: got {maddroe,mrw,miss,mstrobe}=%b required 1110", {b0.MAddrOE, b0.MRW, b0.Miss, b0.MStrobe});
            end
            cyc();
        end
        b0.mSDR_RxD = 1'b0;
        b0.MGrant = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (d1 != 0 || b1.DReady !== 1'b1 || b1.DDataSelect !== 1'b0) begin
            n_fail++;
            $display("FAIL late_restart: got fill_pulses=%0d done_dready=%b dds=%b required 0 1 0", d1, b1.DReady, b1.DDataSelect);
        end
        cyc();
        @(negedge Clk);
        n_checks++;
        if (dr_q.size() != 0 || rw_q.size() != 0 || vw_q.size() != 0 || b0.Miss !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_drain: got pending dr=%0d rw=%0d vw=%0d miss=%b required 0 0 0 0", dr_q.size(), rw_q.size(), vw_q.size(), b0.Miss);
        end
    endtask

    task automatic test_hit();
        cur_idx = 4'd3;
        cur_tag = 4'hA;
        b0.DStrobe = 1'b1;
        b0.DRW = 1'b0;
        cyc();
        b0.DStrobe = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (b0.Hit !== 1'b0 || b0.DReady !== 1'b0) begin
            n_fail++;
            $display("FAIL write_ignored: got hit=%b dready=%b required 0 0", b0.Hit, b0.DReady);
        end
        dr_q.push_back(9'h000);
        b0.mSDR_RxD = 1'b1;
        issue(4'd3, 4'hA, 2);
        @(negedge Clk);
        n_checks++;
        if (b0.Hit !== 1'b1 || b0.MStrobe !== 1'b0 || b0.DDataSelect !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_lookup: got hit=%b mstrobe=%b dds=%b required 1 0 0", b0.Hit, b0.MStrobe, b0.DDataSelect);
        end
        cyc();
        b0.mSDR_RxD = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (dr_q.size() != 0 || b0.MStrobe !== 1'b0 || b0.Miss !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_done: got pending=%0d mstrobe=%b miss=%b required 0 0 0", dr_q.size(), b0.MStrobe, b0.Miss);
        end
    endtask

    task automatic test_abort();
        int base;
        base = dr_seen;
        vw_q.push_back(8'b0000_0000);
        for (int i = 0; i < 3; i++) rw_q.push_back(8'd1 << i);
        dr_q.push_back({1'b1, 8'h02});
        vw_q.push_back(8'b0000_0000);
        for (int i = 0; i < 8; i++) rw_q.push_back(8'd1 << i);
        vw_q.push_back(8'b1010_0000);
        issue(4'd5, 4'h2, 1);
        cyc();
        b0.MGrant = 1'b1;
        cyc();
        for (int b = 0; b < 3; b++) begin
            b0.mSDR_RxD = 1'b1;
            cyc();
        end
        b0.mSDR_RxD = 1'b0;
        b0.MGrant = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (b0.ValidWrite !== 1'b0 || b0.RamWrite !== 8'h00 || b0.TagWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_cycle: got vw=%b ramwrite=%h tagw=%b required 0 00 0", b0.ValidWrite, b0.RamWrite, b0.TagWrite);
        end
        cyc();
        @(negedge Clk);
        n_checks++;
        if (b0.MStrobe !== 1'b1 || b0.Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_retry: got mstrobe=%b line_valid=%b required 1 0", b0.MStrobe, b0.Valid);
        end
        b0.MGrant = 1'b1;
        cyc();
        for (int b = 0; b < 8; b++) begin
            b0.mSDR_RxD = 1'b1;
            cyc();
        end
        b0.mSDR_RxD = 1'b0;
        b0.MGrant = 1'b0;
        cyc();
        @(negedge Clk);
        n_checks++;
        if (dr_seen - base != 1 || dr_q.size() != 0 || rw_q.size() != 0 || vw_q.size() != 0 || b0.Valid !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_total: got dready_pulses=%0d pending=%0d/%0d/%0d valid=%b required 1 0/0/0 1",
                     dr_seen - base, dr_q.size(), rw_q.size(), vw_q.size(), b0.Valid);
        end
    endtask

    task automatic test_reset_mid_fill();
        vw_q.push_back(8'b0000_0000);
        for (int i = 0; i < 3; i++) rw_q.push_back(8'd1 << i);
        issue(4'd3, 4'h5, 6);
        cyc();
        b0.MGrant = 1'b1;
        cyc();
        for (int b = 0; b < 3; b++) begin
            b0.mSDR_RxD = 1'b1;
            cyc();
        end
        #2;
        Reset = 1'b1;
        #1;
        n_checks++;
        if (outs0 !== 24'h0 || outs1 !== 24'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %h/%h required 000000", outs0, outs1);
        end
        b0.mSDR_RxD = 1'b0;
        b0.MGrant = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        n_checks++;
        if (dr_q.size() != 0 || rw_q.size() != 0 || vw_q.size() != 0 || outs0 !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_drain: got pending=%0d/%0d/%0d outs=%h required 0/0/0 000000", dr_q.size(), rw_q.size(), vw_q.size(), outs0);
        end
        cyc();
        test_miss(4'd3, 4'hA, 0, 1);
    endtask

    task automatic test_flush();
        vw_q.push_back(8'b0000_0000);
        for (int i = 0; i < 8; i++) rw_q.push_back(8'd1 << i);
        dr_q.push_back({1'b1, 8'h08});
        vw_q.push_back(8'b1010_0000);
        for (int i = 0; i < 16; i++) vw_q.push_back({3'b010, i == 15, 4'(i)});
        issue(4'd6, 4'h1, 3);
        cyc();
        b0.MGrant = 1'b1;
        cyc();
        for (int b = 0; b < 8; b++) begin
            b0.mSDR_RxD = 1'b1;
            b0.Flush = b == 2;
            cyc();
        end
        b0.mSDR_RxD = 1'b0;
        b0.MGrant = 1'b0;
        b0.Flush = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (b0.IndexSel !== 1'b0 || b0.MRW !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_waits: got isel=%b mrw=%b required 0 0", b0.IndexSel, b0.MRW);
        end
        cyc();
        cyc();
        for (int i = 0; i < 16; i++) cyc();
        @(negedge Clk);
        n_checks++;
        if (vw_q.size() != 0 || rw_q.size() != 0 || dr_q.size() != 0 || b0.IndexSel !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_pending: got pending=%0d/%0d/%0d isel=%b required 0/0/0 0", vw_q.size(), rw_q.size(), dr_q.size(), b0.IndexSel);
        end
        for (int i = 0; i < 16; i++) vw_q.push_back({3'b010, i == 15, 4'(i)});
        cur_idx = 4'd6;
        cur_tag = 4'h1;
        b0.Flush = 1'b1;
        b0.DStrobe = 1'b1;
        b0.DRW = 1'b1;
        cyc();
        b0.DStrobe = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (b0.IndexSel !== 1'b1 || b0.Hit !== 1'b0 || b0.DReady !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_priority: got isel=%b hit=%b dready=%b required 1 0 0", b0.IndexSel, b0.Hit, b0.DReady);
        end
        cyc();
        b0.Flush = 1'b0;
        for (int i = 0; i < 15; i++) cyc();
        @(negedge Clk);
        n_checks++;
        if (vw_q.size() != 0 || b0.IndexSel !== 1'b0 || b0.Hit !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_direct: got pending=%0d isel=%b hit=%b required 0 0 0", vw_q.size(), b0.IndexSel, b0.Hit);
        end
        cyc();
        @(negedge Clk);
        n_checks++;
        if (b0.MStrobe !== 1'b0 || b0.DReady !== 1'b0) begin
            n_fail++;
            $display("FAIL strobe_dropped: got mstrobe=%b dready=%b required 0 0", b0.MStrobe, b0.DReady);
        end
    endtask

    initial begin
        test_reset();
        test_miss(4'd3, 4'hA, 5, 3);
        test_hit();
        test_miss(4'd9, 4'hC, 7, 0);
        test_abort();
        test_reset_mid_fill();
        test_flush();
        test_miss(4'd3, 4'hA, 2, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
